// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if
// Request/result bundle between the execute stage and the HI/LO
// multiply/divide unit.
//   start : request strobe
//   op    : 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//           110/111 no-op
//   A, B  : rs / rt operands
//   HI,LO : architectural HI and LO registers
//   busy  : multiply or divide in progress
//   done  : one-cycle pulse when a multiply/divide result is written
interface hilo_muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        done;

  // Execute stage side: issues requests, observes HI/LO and status.
  modport master (output start, op, A, B, input HI, LO, busy, done);
  // Unit side: consumes requests, owns HI/LO and status.
  modport slave  (input start, op, A, B, output HI, LO, busy, done);
endinterface

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
// Iterative 32-bit multiply/divide unit owning the HI/LO registers.
// Multiplies use a 64-bit shift-add (one multiplier bit per cycle, LSB
// first); divides use restoring division (one quotient bit per cycle, MSB
// first). Signed operations run on magnitudes and are sign-corrected in a
// final FIX cycle, which is also the only cycle that writes HI/LO.
// Ports:
//   clk   : clock, rising-edge
//   reset : asynchronous, active-high, clears all state
//   bus   : hilo_muldiv_if slave modport (start/op/A/B in, HI/LO/busy/done out)
module hilo_muldiv_unit (
  input  logic              clk,
  input  logic              reset,
  hilo_muldiv_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Two's complement negation helpers.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  state_t      state_r;
  state_t      state_s;

  logic [4:0]  cnt_r;
  logic        op_div_r;     // 1: divide, 0: multiply
  logic        neg_q_r;      // negate product / quotient
  logic        neg_rem_r;    // negate remainder (dividend was negative)
  logic        div0_r;       // divisor was zero
  logic [31:0] a_orig_r;     // unmodified dividend for divide-by-zero
  logic [63:0] mcand_r;      // multiplicand, shifted left each iteration
  logic [31:0] b_r;          // multiplier (shifted right) or divisor magnitude
  logic [63:0] prod_r;       // product accumulator
  logic [31:0] rem_r;        // partial remainder
  logic [31:0] dvd_r;        // dividend bits out of MSB, quotient bits into LSB
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        busy_r;
  logic        done_r;

  logic        idle_req_s;
  logic        accept_md_s;
  logic        mthi_s;
  logic        mtlo_s;
  logic        signed_op_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [63:0] mul_sum_s;
  logic [32:0] rem_shift_s;
  logic [32:0] rem_trial_s;
  logic        q_bit_s;
  logic [63:0] prod_fix_s;
  logic [31:0] quo_fix_s;
  logic [31:0] rem_fix_s;

  // Request decode and operand magnitude selection.
  always_comb begin
    idle_req_s  = (state_r == IDLE) && bus.start;
    accept_md_s = idle_req_s && (bus.op[2] == 1'b0);
    mthi_s      = idle_req_s && (bus.op == 3'b100);
    mtlo_s      = idle_req_s && (bus.op == 3'b101);
    signed_op_s = (bus.op[0] == 1'b0);
    if (signed_op_s && bus.A[31]) begin
      a_mag_s = neg32(bus.A);
    end else begin
      a_mag_s = bus.A;
    end
    if (signed_op_s && bus.B[31]) begin
      b_mag_s = neg32(bus.B);
    end else begin
      b_mag_s = bus.B;
    end
  end

  // One multiply/divide iteration and the final sign correction.
  always_comb begin
    mul_sum_s   = prod_r + (b_r[0] ? mcand_r : 64'd0);
    rem_shift_s = {rem_r, dvd_r[31]};
    rem_trial_s = rem_shift_s - {1'b0, b_r};
    // Trial subtraction did not borrow: quotient bit is 1.
    q_bit_s     = ~rem_trial_s[32];
    if (neg_q_r) begin
      prod_fix_s = neg64(prod_r);
      quo_fix_s  = neg32(dvd_r);
    end else begin
      prod_fix_s = prod_r;
      quo_fix_s  = dvd_r;
    end
    if (neg_rem_r) begin
      rem_fix_s = neg32(rem_r);
    end else begin
      rem_fix_s = rem_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_md_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == 5'd31) begin
          state_s = FIX;
        end else begin
          state_s = RUN;
        end
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Operand capture and iterative datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r     <= 5'd0;
      op_div_r  <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      div0_r    <= 1'b0;
      a_orig_r  <= 32'd0;
      mcand_r   <= 64'd0;
      b_r       <= 32'd0;
      prod_r    <= 64'd0;
      rem_r     <= 32'd0;
      dvd_r     <= 32'd0;
    end else if (accept_md_s) begin
      cnt_r     <= 5'd0;
      op_div_r  <= bus.op[1];
      neg_q_r   <= signed_op_s & (bus.A[31] ^ bus.B[31]);
      neg_rem_r <= signed_op_s & bus.A[31];
      div0_r    <= (bus.B == 32'd0);
      a_orig_r  <= bus.A;
      mcand_r   <= {32'd0, a_mag_s};
      b_r       <= b_mag_s;
      prod_r    <= 64'd0;
      rem_r     <= 32'd0;
      dvd_r     <= a_mag_s;
    end else if (state_r == RUN) begin
      cnt_r <= cnt_r + 5'd1;
      if (op_div_r) begin
        // Restored remainder always fits 32 bits since it is below the divisor.
        rem_r <= q_bit_s ? rem_trial_s[31:0] : rem_shift_s[31:0];
        dvd_r <= {dvd_r[30:0], q_bit_s};
      end else begin
        prod_r  <= mul_sum_s;
        mcand_r <= {mcand_r[62:0], 1'b0};
        b_r     <= {1'b0, b_r[31:1]};
      end
    end
  end

  // HI/LO: written by MTHI/MTLO in IDLE or by the FIX cycle only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (state_r == FIX) begin
      if (!op_div_r) begin
        hi_r <= prod_fix_s[63:32];
        lo_r <= prod_fix_s[31:0];
      end else if (div0_r) begin
        hi_r <= a_orig_r;
        lo_r <= 32'hFFFF_FFFF;
      end else begin
        hi_r <= rem_fix_s;
        lo_r <= quo_fix_s;
      end
    end else if (mthi_s) begin
      hi_r <= bus.A;
    end else if (mtlo_s) begin
      lo_r <= bus.A;
    end
  end

  // Status flags: busy spans accept..FIX, done pulses on the FIX edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= (state_r == FIX);
      if (accept_md_s) begin
        busy_r <= 1'b1;
      end else if (state_r == FIX) begin
        busy_r <= 1'b0;
      end
    end
  end

  assign bus.HI   = hi_r;
  assign bus.LO   = lo_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit
// Self-checking bench: directed cases plus randomized ops compared against
// a plain-arithmetic reference model of HI/LO.
module tb_hilo_muldiv_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  always #5 clk = ~clk;

  hilo_muldiv_if bus();

  hilo_muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result {HI,LO} from MIPS semantics.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa64, sb64;
    int     sa, sb, q, r;
    logic [63:0] res;
    res = 64'd0;
    case (op)
      3'd0: begin
        sa64 = longint'($signed(a));
        sb64 = longint'($signed(b));
        res  = 64'(sa64 * sb64);
      end
      3'd1: res = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
        else begin
          sa = $signed(a);
          sb = $signed(b);
          q  = sa / sb;
          r  = sa % sb;
          res = {r, q};
        end
      end
      3'd3: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = {hi_m, lo_m};
    endcase
    return res;
  endfunction

  // Present a request for one edge; called #1 after a rising edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
  endtask

  // Multiply/divide with optional ignored MT request at cycle mt_at.
  task automatic do_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int mt_at, input logic [2:0] mt_op, input logic [31:0] mt_data);
    logic [63:0] exp;
    int cyc, busy_cnt, hold_err;
    exp = ref_md(op, a, b);
    issue(op, a, b);
    cyc = 0; busy_cnt = 0; hold_err = 0;
    while (!bus.done && cyc < 40) begin
      if (bus.busy) busy_cnt++;
      if (bus.HI !== hi_m || bus.LO !== lo_m) hold_err++;
      if (cyc == mt_at) begin
        bus.start = 1'b1; bus.op = mt_op; bus.A = mt_data;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.start = 1'b0;
    check("latency", 32'(cyc), 32'd33);
    check("busy_cycles", 32'(busy_cnt), 32'd33);
    check("hold", 32'(hold_err), 32'd0);
    check("busy_low_at_done", {31'd0, bus.busy}, 32'd0);
    check("HI", bus.HI, exp[63:32]);
    check("LO", bus.LO, exp[31:0]);
    hi_m = exp[63:32];
    lo_m = exp[31:0];
    @(posedge clk);
    #1;
    check("done_pulse_width", {31'd0, bus.done}, 32'd0);
  endtask

  // MTHI/MTLO/no-op: one-edge effect, busy never rises.
  task automatic do_mt(input logic [2:0] op, input logic [31:0] a);
    issue(op, a, $urandom);
    if (op == 3'b100) hi_m = a;
    else if (op == 3'b101) lo_m = a;
    check("mt_busy", {31'd0, bus.busy}, 32'd0);
    check("mt_HI", bus.HI, hi_m);
    check("mt_LO", bus.LO, lo_m);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          done_seen;
    hi_m = 32'd0;
    lo_m = 32'd0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.A = 32'd0;
    bus.B = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_HI", bus.HI, 32'd0);
    check("rst_LO", bus.LO, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases.
    do_md(3'd1, 32'hFFFF_FFFF, 32'd2, -1, 3'd0, 32'd0);
    do_md(3'd0, 32'hFFFF_FFFD, 32'd5, -1, 3'd0, 32'd0);
    check("mult_neg_HI", bus.HI, 32'hFFFF_FFFF);
    check("mult_neg_LO", bus.LO, 32'hFFFF_FFF1);
    do_md(3'd1, 32'hFFFF_FFFD, 32'd5, -1, 3'd0, 32'd0);
    check("multu_HI", bus.HI, 32'h0000_0004);
    do_md(3'd2, 32'hFFFF_FFF9, 32'd2, -1, 3'd0, 32'd0);
    check("div_neg_LO", bus.LO, 32'hFFFF_FFFD);
    check("div_neg_HI", bus.HI, 32'hFFFF_FFFF);
    do_md(3'd3, 32'd7, 32'd2, -1, 3'd0, 32'd0);
    do_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, 3'd0, 32'd0);
    check("div_ovf_LO", bus.LO, 32'h8000_0000);
    do_md(3'd3, 32'h0000_1234, 32'd0, -1, 3'd0, 32'd0);
    check("divz_HI", bus.HI, 32'h0000_1234);
    do_md(3'd2, 32'hFFFF_FF00, 32'd0, -1, 3'd0, 32'd0);
    check("sdivz_HI", bus.HI, 32'hFFFF_FF00);

    do_mt(3'b100, 32'hCAFE_F00D);
    check("mthi", bus.HI, 32'hCAFE_F00D);
    // MTLO during RUN must be ignored.
    do_md(3'd1, 32'd3, 32'd3, 5, 3'b101, 32'h0000_DEAD);
    check("mtlo_ignored_LO", bus.LO, 32'd9);
    check("mtlo_ignored_HI", bus.HI, 32'd0);

    // Reset mid-divide.
    issue(3'd3, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_HI", bus.HI, 32'd0);
    check("midrst_LO", bus.LO, 32'd0);
    hi_m = 32'd0;
    lo_m = 32'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) done_seen++;
    end
    check("midrst_no_done", 32'(done_seen), 32'd0);
    do_md(3'd1, 32'd6, 32'd7, -1, 3'd0, 32'd0);
    check("after_rst_LO", bus.LO, 32'd42);

    // Randomized mix of all opcodes.
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if (op[2] == 1'b0) do_md(op, a, b, -1, 3'd0, 32'd0);
      else do_mt(op, a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
